// File: rtl/xconf_seq_pkg.sv
// Shared definitions for the configuration script player: default widths,
// script entry layout and sequencer state encoding.
package xconf_seq_pkg;

    localparam int CONF_REG_ADDR_W = 6;
    localparam int MEM_ADDR_W      = 11;
    localparam int SCRIPT_PTR_W    = 6;

    localparam int ENTRY_W        = CONF_REG_ADDR_W + MEM_ADDR_W;
    localparam int ENTRY_DATA_LSB = 0;
    localparam int ENTRY_DATA_MSB = MEM_ADDR_W - 1;
    localparam int ENTRY_ADDR_LSB = MEM_ADDR_W;
    localparam int ENTRY_ADDR_MSB = ENTRY_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/xconf_seq_ram.sv
// Script storage: one write port, one synchronous read port with 1-cycle latency.
// The read register holds its value while no read is issued, so it doubles as a skid slot.
module xconf_seq_ram #(
    parameter int ENTRY_W = 17,
    parameter int PTR_W   = 6,
    parameter int DEPTH   = 2 ** PTR_W
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [PTR_W-1:0]   raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/xconf_seq.sv
// Replays a slice of a host-loaded (addr, data) script onto the configuration
// register port, one write per cycle, yielding to direct host accesses.
module xconf_seq
    import xconf_seq_pkg::*;
#(
    parameter int ADDR_W = CONF_REG_ADDR_W,
    parameter int DATA_W = MEM_ADDR_W,
    parameter int PTR_W  = SCRIPT_PTR_W,
    parameter int DEPTH  = 2 ** PTR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_req,
    input  logic                     host_rnw,
    input  logic [ADDR_W-1:0]        host_addr,
    input  logic [DATA_W-1:0]        host_data,
    input  logic                     ld_we,
    input  logic [PTR_W-1:0]         ld_addr,
    input  logic [ADDR_W+DATA_W-1:0] ld_data,
    input  logic                     start,
    input  logic [PTR_W-1:0]         start_ptr,
    input  logic [PTR_W:0]           start_len,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     conf_req,
    output logic                     conf_rnw,
    output logic [ADDR_W-1:0]        conf_addr,
    output logic [DATA_W-1:0]        conf_data
);

    localparam int                 E_W       = ADDR_W + DATA_W;
    localparam logic [PTR_W:0]     DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]     ONE_CNT   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]   ONE_PTR   = PTR_W'(1);

    seq_state_e       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W:0]   rem_q;
    logic             rd_vld_q;
    logic             hold_vld_q;
    logic [E_W-1:0]   hold_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [E_W-1:0]   ram_rdata;
    logic             ram_we;
    logic             in_run;
    logic             head_vld;
    logic [E_W-1:0]   head;
    logic             issue;
    logic [1:0]       left;
    logic             rd_en;
    logic             last;
    logic [PTR_W:0]   clamp_len;

    xconf_seq_ram #(
        .ENTRY_W (E_W),
        .PTR_W   (PTR_W),
        .DEPTH   (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .re_i    (rd_en),
        .raddr_i (ptr_q),
        .rdata_o (ram_rdata)
    );

    // Skid pair: the RAM read register is the in-flight slot, hold_q the second.
    // The oldest entry sits in hold_q whenever hold_q is valid.
    always_comb begin
        in_run    = (state_q == ST_RUN);
        ram_we    = ld_we && !in_run;
        head_vld  = in_run && (hold_vld_q || rd_vld_q);
        head      = hold_vld_q ? hold_q : ram_rdata;
        issue     = head_vld && !host_req;
        left      = ({1'b0, hold_vld_q} + {1'b0, rd_vld_q}) - {1'b0, issue};
        rd_en     = in_run && !abort && (rem_q != '0) && (left != 2'd2);
        last      = in_run && (rem_q == '0) && (left == 2'd0);
        clamp_len = (start_len > DEPTH_CNT) ? DEPTH_CNT : start_len;
    end

    always_comb begin
        conf_req  = 1'b0;
        conf_rnw  = 1'b1;
        conf_addr = '0;
        conf_data = '0;
        if (host_req) begin
            conf_req  = 1'b1;
            conf_rnw  = host_rnw;
            conf_addr = host_addr;
            conf_data = host_data;
        end else if (head_vld) begin
            conf_req  = 1'b1;
            conf_rnw  = 1'b0;
            conf_addr = head[E_W-1:DATA_W];
            conf_data = head[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            rd_vld_q   <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (start) begin
                        err_q <= 1'b0;
                        if (start_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q   <= start_ptr;
                            rem_q   <= clamp_len;
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (ld_we || (start && !abort)) begin
                        err_q <= 1'b1;
                    end
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        rem_q      <= '0;
                        rd_vld_q   <= 1'b0;
                        hold_vld_q <= 1'b0;
                    end else begin
                        if (rd_en) begin
                            ptr_q <= ptr_q + ONE_PTR;
                            rem_q <= rem_q - ONE_CNT;
                        end
                        // With both slots stalled, the read register keeps its entry.
                        rd_vld_q   <= rd_en || (left == 2'd2);
                        hold_vld_q <= (left != 2'd0);
                        if (rd_vld_q && (hold_vld_q == issue)) begin
                            hold_q <= ram_rdata;
                        end
                        if (last) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_xconf_seq.sv
// Self-checking bench for xconf_seq: a queue-based model of the script replay
// predicts every conf port cycle, busy/done/err, under random host contention.
module tb_xconf_seq;

    localparam int AW = 6;
    localparam int DW = 11;
    localparam int PW = 6;
    localparam int EW = AW + DW;
    localparam int ND = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req, host_rnw;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          ld_we;
    logic [PW-1:0] ld_addr;
    logic [EW-1:0] ld_data;
    logic          start;
    logic [PW-1:0] start_ptr;
    logic [PW:0]   start_len;
    logic          abort;
    logic          busy, done, err;
    logic          conf_req, conf_rnw;
    logic [AW-1:0] conf_addr;
    logic [DW-1:0] conf_data;

    logic [EW-1:0] mem_m [ND];
    logic          exp_err;
    int            checks = 0;
    int            errors = 0;

    xconf_seq dut (
        .clk       (clk),
        .rst       (rst),
        .host_req  (host_req),
        .host_rnw  (host_rnw),
        .host_addr (host_addr),
        .host_data (host_data),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .start_ptr (start_ptr),
        .start_len (start_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .conf_req  (conf_req),
        .conf_rnw  (conf_rnw),
        .conf_addr (conf_addr),
        .conf_data (conf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int a, input logic [EW-1:0] d);
        ld_we   = 1'b1;
        ld_addr = PW'(a);
        ld_data = d;
        mem_m[a] = d;
        tick();
        ld_we = 1'b0;
    endtask

    // Expected behaviour: from the second cycle after start, every cycle without a
    // host request retires the next script entry; done follows the last retirement.
    task automatic run_script(input int p, input int len, input int host_pct, input int hmask,
                              input bit intrude, input bit co_ld, input logic [EW-1:0] co_d,
                              input int exp_done_c);
        logic [EW-1:0] q[$];
        logic [EW-1:0] e;
        int            n;
        bit            fin;
        bit            pre_empty;
        n   = (len > ND) ? ND : len;
        fin = 1'b0;
        if (co_ld) begin
            ld_we = 1'b1; ld_addr = PW'(p); ld_data = co_d; mem_m[p] = co_d;
        end
        start = 1'b1; start_ptr = PW'(p); start_len = (PW+1)'(len);
        for (int i = 0; i < n; i++) q.push_back(mem_m[(p + i) % ND]);
        exp_err = 1'b0;
        tick();
        start = 1'b0; ld_we = 1'b0;
        for (int c = 1; c < 400 && !fin; c++) begin
            pre_empty = (q.size() == 0);
            host_req  = (c > 1) && (((hmask >> c) & 1) == 1 || $urandom_range(99) < host_pct);
            host_rnw  = 1'($urandom);
            host_addr = AW'($urandom);
            host_data = DW'($urandom);
            if (intrude && c == 3) begin
                start = 1'b1; start_ptr = PW'($urandom); start_len = 7'd5;
                ld_we = 1'b1; ld_addr = PW'(p); ld_data = ~mem_m[p];
            end
            @(negedge clk);
            chk("busy", busy, !pre_empty);
            chk("done", done, pre_empty);
            chk("err", err, exp_err);
            if (host_req) begin
                chk("host_req", conf_req, 1);
                chk("host_rnw", conf_rnw, host_rnw);
                chk("host_addr", conf_addr, host_addr);
                chk("host_data", conf_data, host_data);
            end else if (c > 1 && !pre_empty) begin
                e = q.pop_front();
                chk("seq_req", conf_req, 1);
                chk("seq_rnw", conf_rnw, 0);
                chk("seq_addr", conf_addr, e[EW-1:DW]);
                chk("seq_data", conf_data, e[DW-1:0]);
            end else begin
                chk("idle_req", conf_req, 0);
            end
            if (pre_empty) begin
                fin = 1'b1;
                if (exp_done_c > 0) chk("done_cycle", c, exp_done_c);
            end
            tick();
            if (intrude && c == 3) begin
                start = 1'b0; ld_we = 1'b0; exp_err = 1'b1;
            end
        end
        host_req = 1'b0;
        chk("run_timeout", fin, 1);
        $display("run ptr=%0d len=%0d host_pct=%0d intrude=%0d co_ld=%0d checks=%0d errors=%0d",
                 p, len, host_pct, intrude, co_ld, checks, errors);
    endtask

    initial begin
        rst = 1'b0; host_req = 1'b0; host_rnw = 1'b0; host_addr = '0; host_data = '0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; start_ptr = '0;
        start_len = '0; abort = 1'b0; exp_err = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req", conf_req, 0);
        chk("rst_rnw", conf_rnw, 1);
        chk("rst_addr", conf_addr, 0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < ND; i++) ld(i, EW'($urandom));
        ld(0, {6'd0,  11'd0});
        ld(1, {6'd8,  11'd5});
        ld(2, {6'd20, 11'd3});
        ld(3, {6'd33, 11'd7});

        run_script(0, 4, 0, 0, 1'b0, 1'b0, '0, 6);
        run_script(0, 4, 0, 'b11000, 1'b0, 1'b0, '0, 8);
        run_script(62, 4, 0, 0, 1'b0, 1'b0, '0, 6);
        run_script(5, 0, 0, 0, 1'b0, 1'b0, '0, 1);
        run_script(10, 70, 0, 0, 1'b0, 1'b0, '0, 66);

        run_script(7, 8, 20, 0, 1'b1, 1'b0, '0, 0);
        @(negedge clk);
        chk("err_sticky", err, 1);
        tick();
        run_script(7, 1, 0, 0, 1'b0, 1'b0, '0, 3);
        run_script(20, 2, 0, 0, 1'b0, 1'b1, EW'($urandom), 4);

        for (int r = 0; r < 6; r++)
            run_script(int'($urandom_range(63)), int'($urandom_range(70)), 35, 0, 1'b0, 1'b0, '0, 0);

        // abort in T+3 of a 4-entry run, with a start in the same cycle
        start = 1'b1; start_ptr = '0; start_len = 7'd4;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_e0", conf_addr, mem_m[0][EW-1:DW]);
        tick();
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("abort_e1", conf_data, mem_m[1][DW-1:0]);
        tick();
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_req", conf_req, 0);
        chk("abort_err", err, 0);
        chk("abort_done", done, 0);
        tick();
        @(negedge clk);
        chk("abort_nodone", done, 0);
        tick();
        $display("abort step checks=%0d errors=%0d", checks, errors);

        // reset mid-run after an illegal load
        start = 1'b1; start_ptr = '0; start_len = 7'd8;
        tick();
        start = 1'b0;
        tick();
        ld_we = 1'b1; ld_addr = 6'd9; ld_data = ~mem_m[9];
        tick();
        ld_we = 1'b0;
        @(negedge clk);
        chk("mid_err", err, 1);
        chk("mid_req", conf_req, 1);
        #1 rst = 1'b0;
        #1;
        chk("arst_req", conf_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        chk("arst_done", done, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        $display("reset step checks=%0d errors=%0d", checks, errors);
        run_script(0, 10, 25, 0, 1'b0, 1'b0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xconf_seq.md
Name: xconf_seq

Overview:
- Configuration script player for the Versat configuration register.
- Holds a host-loaded script of (conf address, data) pairs in a local RAM and replays a selected slice onto the configuration register's req/rnw/addr/data_in port, one write per cycle.
- Shares that port with direct host accesses; the host always wins and the sequencer stalls without losing entries.
- Sits between the controller/host bus and the configuration register, so full datapath reconfiguration needs a single start command instead of one host write per field.

Parameters:
- ADDR_W, 6: conf register address width (covers CONF_CLEAR and all unit fields).
- DATA_W, 11: conf data width (equals MEM_ADDR_W).
- PTR_W, 6: script pointer width.
- DEPTH, 64: script entries, 2**PTR_W.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- host_req  in  1  direct host access to conf register
- host_rnw  in  1  host read-not-write
- host_addr  in  ADDR_W  host conf address
- host_data  in  DATA_W  host conf write data
- ld_we  in  1  script RAM write strobe
- ld_addr  in  PTR_W  script RAM write index
- ld_data  in  ADDR_W+DATA_W  entry, {addr, data}, addr in MSBs
- start  in  1  one-cycle start pulse
- start_ptr  in  PTR_W  first entry index
- start_len  in  PTR_W+1  entry count, 0..DEPTH
- abort  in  1  cancel running script
- busy  out  1  script in progress
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky: illegal load or start while busy
- conf_req  out  1  to conf register req
- conf_rnw  out  1  to conf register rnw
- conf_addr  out  ADDR_W  to conf register addr
- conf_data  out  DATA_W  to conf register data_in

Behaviour:
- Reset (rst=0, async): state IDLE, busy=0, done=0, err=0, hold register empty, pointer=0, remaining count=0. Script RAM contents are not reset.
- Conf port mux (combinational):
  - host_req=1: conf_* = host_*, regardless of sequencer state.
  - host_req=0 and hold valid in RUN: conf_req=1, conf_rnw=0, conf_addr/conf_data = hold entry.
  - Otherwise conf_req=0, conf_rnw=1, conf_addr/conf_data = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with start_len=0: go to DONE, no writes.
  - start=1 with start_len>0: latch ptr=start_ptr and rem=start_len, go to RUN.
- RUN:
  - Script RAM has synchronous read, 1-cycle latency. The read is issued when rem>0 and (hold empty or hold issued this cycle or a read is already in flight and will fill a freed slot). Each read does ptr+1 (mod DEPTH) and rem-1.
  - A 2-entry skid (read-in-flight + hold) keeps throughput at 1 write/cycle with no entry loss under host stalls.
  - Hold is issued in any cycle with host_req=0.
  - When rem=0, nothing is in flight and hold is empty (last entry issued): go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 exactly while in RUN.
- Latency: start sampled at edge T. First conf_req is high in cycle T+2, after the RAM read in T+1. With no contention, N entries occupy cycles T+2..T+N+1 and done pulses in T+N+2. Each host_req cycle during RUN delays completion by one cycle.
- Pointer wrap: ptr wraps DEPTH-1 -> 0 (start_ptr=62, len=4 reads 62,63,0,1).
- start_len > DEPTH is clamped to DEPTH.
- start while busy: ignored, err set.
- ld_we while busy: write suppressed, err set. ld_we in IDLE/DONE writes the RAM.
- A new start clears err.
- Simultaneous ld_we and start in IDLE: the write occurs; the start is taken; the new entry is visible if read at least one cycle later.
- abort=1 in RUN: next edge goes to IDLE, hold and in-flight entry dropped, no done, conf_req from the sequencer low from the next cycle. Writes already issued are not undone. abort in IDLE/DONE has no effect, and DONE still pulses.
- abort and start in the same cycle: abort wins, start ignored, err unchanged.
- Entries are opaque. CONF_CLEAR addresses pass through unmodified. Sequencer never issues reads.
- Reset mid-RUN: immediate return to reset values; conf_req from the sequencer drops asynchronously.

Decomposition:
- Shared package/header xconfseqdefs.vh: state encodings (IDLE, RUN, DONE), entry field positions (ENTRY_ADDR_MSB/LSB, ENTRY_DATA_MSB/LSB), default widths tied to CONF_REG_ADDR_W/MEM_ADDR_W.
- Sub-module xconf_seq_ram: DEPTH x (ADDR_W+DATA_W) single-write, single-synchronous-read RAM. FSM, skid and mux stay in the top.

Test Plan:
- Load entries 0..3 = {CONF_CLEAR,0},{MEM0A ITER,5},{ALU0 FNS,3},{MUL0 SELA,7}; start ptr=0 len=4 -> conf writes in cycles T+2..T+5 in that order, done at T+6, busy high T+1..T+5.
- Same script with host_req=1 during T+3 and T+4 (host write ALU0 SELA=9) -> host write appears in both cycles, script entries 1..3 shifted by 2 cycles with none lost or duplicated, done at T+8.
- start ptr=62 len=4 -> entries 62,63,0,1 issued; start len=0 -> done at T+1, no conf_req.
- start again and ld_we while busy -> both ignored, RAM unchanged, err=1. Next legal start -> err=0.
- abort in T+3 of a len=4 run -> only entries 0,1 written, busy low next cycle, no done pulse.
- rst=0 asserted mid-run -> conf_req/busy/done/err low immediately. After release, a start replays correctly from the unchanged RAM.
